// File: rtl/frame_buffer_pkg.sv
// Shared encodings for the frame buffer: FSM states, command modes and a width helper.
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_CLEAR = 2'b11
  } state_e;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;

  // Keeps counter widths legal for degenerate 1- or 2-entry dimensions.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Single-port synchronous pixel store; one-cycle read latency, read data held when not enabled.
module frame_buffer_ram
  import frame_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// Frame buffer controller: streams pixels into and out of a single-port RAM, or clears it.
//
// state    | meaning
// ST_IDLE  | waiting for start; counters parked
// ST_WRITE | accepting wr stream beats into consecutive addresses
// ST_READ  | presenting one pixel at a time on the rd stream
// ST_CLEAR | writing CLR_VAL to every address, one per cycle
module frame_buffer
  import frame_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 600,
  parameter int IMG_H  = 450,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              rd_eol,
  output logic              rd_eof,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int XW    = clog2_min1(IMG_W);
  localparam int YW    = clog2_min1(IMG_H);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);

  state_e state, state_nxt;
  logic [AW-1:0] addr, addr_inc;
  logic [XW-1:0] x, x_inc;
  logic [YW-1:0] y, y_inc;
  logic          rd_valid_q, rd_valid_nxt;
  logic          done_nxt;
  logic          cnt_clr, cnt_adv;
  logic          at_last_addr, at_eof;

  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign at_last_addr = (addr == ADDR_LAST);
  assign at_eof       = (x == X_LAST) && (y == Y_LAST);

  assign addr_inc = at_last_addr ? '0 : addr + AW'(1);
  assign x_inc    = (x == X_LAST) ? '0 : x + XW'(1);
  assign y_inc    = (x != X_LAST) ? y : ((y == Y_LAST) ? '0 : y + YW'(1));

  always_comb begin
    state_nxt    = state;
    rd_valid_nxt = rd_valid_q;
    done_nxt     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_adv      = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = addr;
    ram_wdata    = wr_data;

    case (state)
      ST_IDLE: begin
        rd_valid_nxt = 1'b0;
        if (start) begin
          case (mode)
            MODE_READ:  begin state_nxt = ST_READ;  cnt_clr = 1'b1; end
            MODE_WRITE: begin state_nxt = ST_WRITE; cnt_clr = 1'b1; end
            MODE_CLEAR: begin state_nxt = ST_CLEAR; cnt_clr = 1'b1; end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        if (wr_valid) begin
          ram_en  = 1'b1;
          ram_we  = 1'b1;
          cnt_adv = 1'b1;
          if (at_last_addr) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_READ: begin
        // The RAM always holds the presented pixel; the next one is fetched on handshake.
        if (!rd_valid_q) begin
          ram_en       = 1'b1;
          rd_valid_nxt = 1'b1;
        end else if (rd_ready) begin
          cnt_adv = 1'b1;
          if (at_eof) begin
            state_nxt    = ST_IDLE;
            rd_valid_nxt = 1'b0;
            done_nxt     = 1'b1;
          end else begin
            ram_en   = 1'b1;
            ram_addr = addr_inc;
          end
        end
      end
      ST_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = CLR_VAL;
        cnt_adv   = 1'b1;
        if (at_last_addr) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (abort && (state != ST_IDLE)) begin
      state_nxt    = ST_IDLE;
      rd_valid_nxt = 1'b0;
      done_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rd_valid_q <= 1'b0;
      done       <= 1'b0;
      addr       <= '0;
      x          <= '0;
      y          <= '0;
    end else begin
      state      <= state_nxt;
      rd_valid_q <= rd_valid_nxt;
      done       <= done_nxt;
      if (cnt_clr) begin
        addr <= '0;
        x    <= '0;
        y    <= '0;
      end else if (cnt_adv) begin
        addr <= addr_inc;
        x    <= x_inc;
        y    <= y_inc;
      end
    end
  end

  frame_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign busy     = (state != ST_IDLE);
  assign wr_ready = (state == ST_WRITE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_rdata : '0;
  assign rd_eol   = rd_valid_q && (x == X_LAST);
  assign rd_eof   = rd_valid_q && at_eof;

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer on a 4x3 frame with CLR_VAL 0x5A.
module tb_frame_buffer;
  import frame_buffer_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       eof;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, wr_valid, rd_ready;
  logic [1:0] mode;
  logic [7:0] wr_data;
  logic       wr_ready, rd_valid, rd_eol, rd_eof, busy, done;
  logic [7:0] rd_data;

  logic [7:0] model [N];
  exp_t       exp_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  frame_buffer #(
    .DATA_W (8),
    .IMG_W  (W),
    .IMG_H  (H),
    .CLR_VAL(8'h5A)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .abort   (abort),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_ready(rd_ready),
    .rd_eol  (rd_eol),
    .rd_eof  (rd_eof),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic start_cmd(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; abort = 1'b0;
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, wr_ready, rd_valid, rd_eol, rd_eof, rd_data} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b wr_ready=%b rd_valid=%b eol=%b eof=%b data=%h, want all 0",
               busy, done, wr_ready, rd_valid, rd_eol, rd_eof, rd_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_frame(input logic [7:0] base, input int n_beats, input bit do_abort);
    int sent = 0;
    int cyc  = 0;
    int dones = 0;
    start_cmd(MODE_WRITE);
    while (sent < n_beats && cyc < 100) begin
      n_tests++;
      if (wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL write_ready: beat %0d got %b want 1", sent, wr_ready);
      end
      if (done === 1'b1) dones++;
      if ((cyc % 3) == 2) begin
        wr_valid = 1'b0;
      end else begin
        wr_valid = 1'b1;
        wr_data  = base + 8'(sent);
        model[sent] = base + 8'(sent);
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    if (do_abort) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_tests++;
      if ({busy, wr_ready, done} !== 3'b000 || dones != 0) begin
        n_fail++;
        $display("FAIL write_abort: busy=%b wr_ready=%b done=%b dones=%0d, want 0 0 0 0",
                 busy, wr_ready, done, dones);
      end
    end else begin
      n_tests++;
      if ({busy, wr_ready, done} !== 3'b001 || dones != 0) begin
        n_fail++;
        $display("FAIL write_done: busy=%b wr_ready=%b done=%b early_dones=%0d, want 0 0 1 0",
                 busy, wr_ready, done, dones);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL write_done_pulse: done=%b one cycle later, want 0", done);
      end
    end
  endtask

  task automatic read_frame(input string tag, input logic [3:0] pat);
    int   cyc = 0;
    int   first_valid = -1;
    int   dones = 0;
    bit   stalled = 1'b0;
    exp_t held, e;
    for (int i = 0; i < N; i++) begin
      e.d   = model[i];
      e.eol = ((i % W) == W - 1);
      e.eof = (i == N - 1);
      exp_q.push_back(e);
    end
    start_cmd(MODE_READ);
    while (exp_q.size() > 0 && cyc < 200) begin
      rd_ready = pat[cyc % 4];
      if (done === 1'b1) dones++;
      if (rd_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (stalled) begin
        n_tests++;
        if (rd_valid !== 1'b1 || {rd_data, rd_eol, rd_eof} !== held) begin
          n_fail++;
          $display("FAIL %s_hold: got v=%b %h/%b/%b want held %h/%b/%b",
                   tag, rd_valid, rd_data, rd_eol, rd_eof, held.d, held.eol, held.eof);
        end
      end
      stalled = 1'b0;
      if (rd_valid === 1'b1 && rd_ready) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({rd_data, rd_eol, rd_eof} !== e) begin
          n_fail++;
          $display("FAIL %s_pixel: got %h eol=%b eof=%b want %h eol=%b eof=%b",
                   tag, rd_data, rd_eol, rd_eof, e.d, e.eol, e.eof);
        end
      end else if (rd_valid === 1'b1) begin
        stalled = 1'b1;
        held = {rd_data, rd_eol, rd_eof};
      end
      cyc++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d pixels outstanding, want 0", tag, exp_q.size());
      exp_q.delete();
    end
    n_tests++;
    if (first_valid != 1) begin
      n_fail++;
      $display("FAIL %s_latency: first rd_valid at cycle %0d after entry, want 1", tag, first_valid);
    end
    @(negedge clk);
    rd_ready = 1'b0;
    n_tests++;
    if ({rd_valid, busy, done} !== 3'b001 || dones != 0) begin
      n_fail++;
      $display("FAIL %s_done: rd_valid=%b busy=%b done=%b early_dones=%0d, want 0 0 1 0",
               tag, rd_valid, busy, done, dones);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done=%b one cycle later, want 0", tag, done);
    end
  endtask

  task automatic test_write_read();
    write_frame(8'h10, N, 1'b0);
    read_frame("rd_full", 4'b1111);
  endtask

  task automatic test_read_stall();
    read_frame("rd_stall", 4'b1001);
  endtask

  task automatic test_clear();
    int k = 0;
    start_cmd(MODE_CLEAR);
    for (int i = 0; i < N; i++) model[i] = 8'h5A;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k != N) begin
      n_fail++;
      $display("FAIL clear_duration: done %0d cycles after entering CLEAR, want %0d", k, N);
    end
    read_frame("rd_clear", 4'b1111);
  endtask

  task automatic test_abort_write();
    write_frame(8'hA0, 5, 1'b1);
    read_frame("rd_abort", 4'b1111);
  endtask

  task automatic test_ignored_start();
    start_cmd(2'b11);
    repeat (2) begin
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL start_mode11: busy=%b want 0", busy);
      end
      @(negedge clk);
    end
    start_cmd(MODE_WRITE);
    start = 1'b1;
    mode  = MODE_READ;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({busy, wr_ready, rd_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL start_while_busy: busy=%b wr_ready=%b rd_valid=%b, want 1 1 0",
               busy, wr_ready, rd_valid);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_read();
    start_cmd(MODE_READ);
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midread_valid: rd_valid=%b before reset, want 1", rd_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, wr_ready, rd_valid, rd_eol, rd_eof, rd_data} !== 14'h0) begin
      n_fail++;
      $display("FAIL midread_reset: busy=%b done=%b wr_ready=%b rd_valid=%b eol=%b eof=%b data=%h, want all 0",
               busy, done, wr_ready, rd_valid, rd_eol, rd_eof, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done, rd_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL midread_after: busy=%b done=%b rd_valid=%b, want 0 0 0", busy, done, rd_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_stall();
    test_clear();
    test_abort_write();
    test_ignored_start();
    test_reset_mid_read();
    read_frame("rd_after_reset", 4'b1111);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 600, pixels per line.
REQ-003 Parameter IMG_H, default 450, lines per frame; DEPTH = IMG_W*IMG_H.
REQ-004 Parameter CLR_VAL, default 0, DATA_W-bit value written by a clear.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle command strobe, sampled only in IDLE.
REQ-008 mode  in  2  command: 00 read, 01 write, 10 clear, 11 reserved (ignored).
REQ-009 abort  in  1  synchronous cancel of the running command.
REQ-010 wr_valid/wr_data/wr_ready  in/in[DATA_W]/out  write stream handshake.
REQ-011 rd_valid/rd_data/rd_ready  out/out[DATA_W]/in  read stream handshake.
REQ-012 rd_eol  out  1  qualifies rd_data as the last pixel of a line.
REQ-013 rd_eof  out  1  qualifies rd_data as the last pixel of the frame.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on normal command completion.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, READ, CLEAR; start in IDLE with mode 00/01/10 moves to READ/WRITE/CLEAR next cycle and zeroes the address, x and y counters.
REQ-017 start SHALL be ignored outside IDLE and with mode 11.
REQ-018 WRITE: wr_ready SHALL be 1 exactly while in WRITE; each cycle with wr_valid&&wr_ready stores wr_data at the current address and increments it; idle cycles preserve the address.
REQ-019 WRITE SHALL end after beat DEPTH-1: IDLE and done=1 on the next cycle, wr_ready=0 from then.
REQ-020 READ: the first rd_valid SHALL assert 2 cycles after the start cycle; once in READ, one pixel per cycle when rd_ready stays high.
REQ-021 While rd_valid&&!rd_ready, rd_data, rd_eol and rd_eof SHALL hold stable and no pixel is skipped or repeated.
REQ-022 rd_eol SHALL be 1 when x==IMG_W-1; rd_eof when x==IMG_W-1 and y==IMG_H-1.
REQ-023 READ SHALL end on the handshake of the rd_eof pixel: rd_valid drops, IDLE and done=1 on the next cycle.
REQ-024 CLEAR SHALL write CLR_VAL to one address per cycle, 0..DEPTH-1, then IDLE with done=1; duration exactly DEPTH cycles.
REQ-025 Address, x, y SHALL wrap to 0 at frame end; x wraps at IMG_W-1, incrementing y.
REQ-026 abort in any non-IDLE state SHALL return to IDLE next cycle, deassert rd_valid/wr_ready, produce no done, leave written locations intact; abort wins over a simultaneous final beat.
REQ-027 Memory contents SHALL persist across commands; a read after a partial write returns old data at unwritten addresses.
REQ-028 Counters SHALL be $clog2(DEPTH) bits (address), $clog2(IMG_W), $clog2(IMG_H).

Reset
REQ-029 rst_n low SHALL force IDLE, busy=0, done=0, wr_ready=0, rd_valid=0, rd_eol=0, rd_eof=0, rd_data=0, counters=0, immediately.
REQ-030 Reset mid-command SHALL abandon it without done; memory contents are not reset.

Structure
REQ-031 Package frame_buffer_pkg SHALL hold the state encoding and the mode constants MODE_READ, MODE_WRITE, MODE_CLEAR.
REQ-032 Storage SHALL be sub-module frame_buffer_ram: single-port synchronous RAM, parameters DATA_W, DEPTH, one-cycle read latency, no reset.

Verification (IMG_W=4, IMG_H=3, DATA_W=8)
REQ-033 Write 12 pixels 0x10..0x1B with wr_valid gaps, then read with rd_ready=1 -> rd_data 0x10..0x1B, rd_eol on 0x13/0x17/0x1B, rd_eof on 0x1B, one done per command.
REQ-034 Read with rd_ready toggling 1,0,0,1 -> each pixel delivered exactly once, data held while stalled.
REQ-035 Clear with CLR_VAL=0x5A -> done exactly 12 cycles after entering CLEAR; subsequent read returns twelve 0x5A.
REQ-036 abort after 5 write beats, then read -> first 5 pixels new, rest unchanged, no done on the aborted write.
REQ-037 rst_n pulsed low mid-read -> outputs zero immediately, IDLE; start asserted during busy or with mode 11 -> ignored.
